// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the extended synchronous FIFO.
package sync_fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // The count must be able to hold DEPTH itself, not only DEPTH-1.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array: synchronous write, asynchronous read, no storage reset.
module fifo_mem #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with guarded push/pop, threshold flags, occupancy, FWFT option,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH      = 8,
    parameter  int unsigned DEPTH      = 8,
    parameter  int unsigned AFULL_LVL  = DEPTH - 1,
    parameter  int unsigned AEMPTY_LVL = 1,
    parameter  int unsigned FWFT       = FIFO_MODE_STD,
    localparam int unsigned CW         = count_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_fifo,
    input  logic             i_we,
    input  logic             i_re,
    output logic [WIDTH-1:0] o_fifo,
    output logic             o_valid,
    output logic             o_fifo_full,
    output logic             o_fifo_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             empty, full, rd_ok, wr_ok;
    logic [WIDTH-1:0] mem_rdata;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign rd_ok = i_re & ~empty;
    assign wr_ok = i_we & (~full | rd_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (i_we & ~wr_ok);
        underflow_d = underflow_q | (i_re & ~rd_ok);
        if (i_flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_ok & ~i_flush),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_fifo),
        .i_raddr (rd_ptr_q),
        .o_rdata (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Masked while empty so the head never shows stale or uninitialised storage.
        assign o_fifo  = empty ? '0 : mem_rdata;
        assign o_valid = ~empty;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        logic             valid_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else if (i_flush) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_ok;
                if (rd_ok) dout_q <= mem_rdata;
            end
        end

        assign o_fifo  = dout_q;
        assign o_valid = valid_q;
    end

    assign o_fifo_full    = full;
    assign o_fifo_empty   = empty;
    assign o_almost_full  = (count_q >= CW'(AFULL_LVL));
    assign o_almost_empty = (count_q <= CW'(AEMPTY_LVL));
    assign o_count        = count_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule
